// File: rtl/tft_init_sequencer.sv
// tft_init_sequencer: panel hard reset, init command list, window setup, then frame streaming with continuous refresh.
// Latency: command words come straight from the sequence index; a pixel accepted on pix_* is on out_* the next cycle.
// Backpressure: out_ready=0 holds out_* stable; pix_ready = !out_valid || out_ready while pixels remain in the frame.
//
// Ports:
//   MasterCLK, sys_rst_n        clock, asynchronous active-low reset
//   start                       one-cycle kick, only honoured in IDLE
//   out_data/out_dc/out_byte    word to the SPI serializer (dc 0=command, byte 1=8-bit in out_data[7:0])
//   out_valid/out_ready         word handshake
//   pix_data/pix_valid/pix_ready RGB565 pixel input handshake
//   tft_rst_n, busy, frame_done panel reset, activity flag, end-of-frame pulse
// Build option: define TFT_SEQ_TESTPAT_EN to replace the pixel input with a left-red / right-blue test pattern.
module tft_init_sequencer #(
  parameter int RST_CYC   = 100000,
  parameter int DELAY_CYC = 600000,
  parameter int WIDTH     = 240,
  parameter int HEIGHT    = 320
) (
  input  logic        MasterCLK,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [15:0] out_data,
  output logic        out_dc,
  output logic        out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        tft_rst_n,
  output logic        busy,
  output logic        frame_done
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = ($clog2(NPIX + 1) > 17) ? $clog2(NPIX + 1) : 17;

  localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYC - 1);
  localparam logic [15:0] X_END    = 16'(WIDTH - 1);
  localparam logic [15:0] Y_END    = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, HWRST, HWWAIT, INIT, DELAY, WINDOW, STREAM} state_t;

  state_t             state_q, state_nxt;
  logic [31:0]        cnt_q, cnt_nxt;
  logic [3:0]         idx_q, idx_nxt;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_nxt;
  logic               frame_done_nxt;

`ifdef TFT_SEQ_TESTPAT_EN
  localparam int              COL_W    = $clog2(WIDTH) + 1;
  localparam logic [COL_W-1:0] COL_HALF = COL_W'(WIDTH / 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  logic [COL_W-1:0]   col_q, col_nxt;
`else
  localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(NPIX);
  // Single-entry output register for the pixel path; pix_cnt counts pixels taken into it.
  logic               pix_vld_q, pix_vld_nxt;
  logic [15:0]        pix_dat_q, pix_dat_nxt;
`endif

  // {dc, byte} for the power-up command list.
  function automatic logic [8:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = {1'b0, 8'h01};  // software reset
      4'd1:    init_word = {1'b0, 8'h11};  // sleep out, followed by DELAY
      4'd2:    init_word = {1'b0, 8'h3A};  // pixel format
      4'd3:    init_word = {1'b1, 8'h55};  // 16 bpp
      4'd4:    init_word = {1'b0, 8'h36};  // memory access control
      4'd5:    init_word = {1'b1, 8'h48};
      default: init_word = {1'b0, 8'h29};  // display on
    endcase
  endfunction

  // {dc, byte} for the column/row window followed by memory write.
  function automatic logic [8:0] window_word(input logic [3:0] i);
    case (i)
      4'd0:    window_word = {1'b0, 8'h2A};
      4'd1:    window_word = {1'b1, 8'h00};
      4'd2:    window_word = {1'b1, 8'h00};
      4'd3:    window_word = {1'b1, X_END[15:8]};
      4'd4:    window_word = {1'b1, X_END[7:0]};
      4'd5:    window_word = {1'b0, 8'h2B};
      4'd6:    window_word = {1'b1, 8'h00};
      4'd7:    window_word = {1'b1, 8'h00};
      4'd8:    window_word = {1'b1, Y_END[15:8]};
      4'd9:    window_word = {1'b1, Y_END[7:0]};
      default: window_word = {1'b0, 8'h2C};
    endcase
  endfunction

  assign busy = (state_q != IDLE);

  always_comb begin
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    idx_nxt        = idx_q;
    pix_cnt_nxt    = pix_cnt_q;
    frame_done_nxt = 1'b0;
    out_valid      = 1'b0;
    out_data       = 16'h0000;
    out_dc         = 1'b0;
    out_byte       = 1'b0;
    pix_ready      = 1'b0;
`ifdef TFT_SEQ_TESTPAT_EN
    col_nxt        = col_q;
`else
    pix_vld_nxt    = pix_vld_q;
    pix_dat_nxt    = pix_dat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = HWRST;
          cnt_nxt   = 32'd0;
        end
      end
      HWRST: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = HWWAIT;
          cnt_nxt   = 32'd0;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      HWWAIT: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = INIT;
          cnt_nxt   = 32'd0;
          idx_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      INIT: begin
        out_valid = 1'b1;
        out_byte  = 1'b1;
        {out_dc, out_data[7:0]} = init_word(idx_q);
        if (out_ready) begin
          if (idx_q == 4'd1) begin
            // Sleep-out needs settling time; resume at the pixel-format command.
            state_nxt = DELAY;
            cnt_nxt   = 32'd0;
            idx_nxt   = 4'd2;
          end else if (idx_q == 4'd6) begin
            state_nxt = WINDOW;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx_q + 4'd1;
          end
        end
      end
      DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_nxt = INIT;
          cnt_nxt   = 32'd0;
        end else begin
          cnt_nxt = cnt_q + 32'd1;
        end
      end
      WINDOW: begin
        out_valid = 1'b1;
        out_byte  = 1'b1;
        {out_dc, out_data[7:0]} = window_word(idx_q);
        if (out_ready) begin
          if (idx_q == 4'd10) begin
            state_nxt   = STREAM;
            idx_nxt     = 4'd0;
            pix_cnt_nxt = '0;
`ifdef TFT_SEQ_TESTPAT_EN
            col_nxt     = '0;
`endif
          end else begin
            idx_nxt = idx_q + 4'd1;
          end
        end
      end
      STREAM: begin
        out_dc = 1'b1;
`ifdef TFT_SEQ_TESTPAT_EN
        out_valid = 1'b1;
        out_data  = (col_q < COL_HALF) ? 16'hF800 : 16'h001F;
        if (out_ready) begin
          pix_cnt_nxt = pix_cnt_q + PIX_W'(1);
          col_nxt     = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
          if (pix_cnt_q == PIX_LAST) begin
            state_nxt      = WINDOW;
            frame_done_nxt = 1'b1;
          end
        end
`else
        out_valid = pix_vld_q;
        out_data  = pix_dat_q;
        pix_ready = (!pix_vld_q || out_ready) && (pix_cnt_q != PIX_TOTAL);
        if (pix_vld_q && out_ready) begin
          pix_vld_nxt = 1'b0;
        end
        if (pix_valid && pix_ready) begin
          pix_vld_nxt = 1'b1;
          pix_dat_nxt = pix_data;
          pix_cnt_nxt = pix_cnt_q + PIX_W'(1);
        end
        // Frame ends when the word holding the last taken pixel leaves.
        if (pix_vld_q && out_ready && (pix_cnt_q == PIX_TOTAL)) begin
          state_nxt      = WINDOW;
          frame_done_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      idx_q      <= 4'd0;
      pix_cnt_q  <= '0;
      frame_done <= 1'b0;
      tft_rst_n  <= 1'b0;
`ifdef TFT_SEQ_TESTPAT_EN
      col_q      <= '0;
`else
      pix_vld_q  <= 1'b0;
      pix_dat_q  <= 16'h0000;
`endif
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      pix_cnt_q  <= pix_cnt_nxt;
      frame_done <= frame_done_nxt;
      // Registered from the next state so the panel reset is low exactly while in HWRST.
      tft_rst_n  <= (state_nxt != HWRST);
`ifdef TFT_SEQ_TESTPAT_EN
      col_q      <= col_nxt;
`else
      pix_vld_q  <= pix_vld_nxt;
      pix_dat_q  <= pix_dat_nxt;
`endif
    end
  end

endmodule
